// File: rtl/tpiu_frame_sync_pkg.sv
// Shared constants and state types for the TPIU trace-port deformatter.
package tpiu_pkg;

    localparam logic [31:0] SYNC_PATTERN = 32'h7FFF_FFFF;
    localparam int          FRAME_BYTES  = 16;
    localparam logic [6:0]  NULL_ID      = 7'h00;
    localparam logic [6:0]  RESERVED_ID  = 7'h7F;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNCED = 1'b1
    } sync_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // True for the two IDs that carry no trace payload.
    function automatic logic id_is_null(input logic [6:0] id);
        return (id == NULL_ID) || (id == RESERVED_ID);
    endfunction

endpackage

// File: rtl/tpiu_frame_deformat.sv
// Drains one committed 16-byte TPIU frame, one index per cycle, decoding
// ID-change bytes and the aux byte, and emits filtered data bytes.
module tpiu_frame_deformat
    import tpiu_pkg::*;
#(
    parameter bit pNULL_DROP = 1'b1
) (
    input  logic                       trace_clk,
    input  logic                       reset,
    input  logic                       commit_i,
    input  logic [8*FRAME_BYTES-1:0]   frame_i,
    output logic                       valid_o,
    output logic [7:0]                 data_o,
    output logic [6:0]                 id_o
);

    logic [8*FRAME_BYTES-1:0] buf_q;
    drain_state_t             state_q;
    logic [3:0]               idx_q;
    logic [6:0]               cur_id_q;
    logic [6:0]               pend_id_q;
    logic                     pend_q;
    logic                     valid_q;
    logic [7:0]               data_q;
    logic [6:0]               id_q;

    logic [7:0]               byte_s;
    logic [7:0]               aux_s;
    logic                     aux_bit_s;
    logic                     id_chg_s;
    logic [7:0]               scan_data_s;
    logic [6:0]               new_id_s;
    logic                     keep_s;

    // Decode the byte at the current drain index.
    always_comb begin
        byte_s      = buf_q[{idx_q, 3'b000} +: 8];
        aux_s       = buf_q[8*FRAME_BYTES-1 -: 8];
        aux_bit_s   = aux_s[idx_q[3:1]];
        new_id_s    = byte_s[7:1];
        id_chg_s    = 1'b0;
        scan_data_s = byte_s;
        if (idx_q[0] == 1'b0) begin
            if (byte_s[0]) begin
                id_chg_s = 1'b1;
            end else begin
                scan_data_s = {byte_s[7:1], aux_bit_s};
            end
        end else begin
            scan_data_s = byte_s;
        end
        keep_s = !(pNULL_DROP && id_is_null(cur_id_q));
    end

    // Drain FSM, ID tracking and registered output strobe.
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            buf_q     <= '0;
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            cur_id_q  <= NULL_ID;
            pend_id_q <= 7'h00;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            id_q      <= 7'h00;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q <= 4'd0;
                end
                DRAIN: begin
                    if (id_chg_s) begin
                        // Aux bit set defers the new ID past the following odd
                        // byte; at index 14 it simply carries into the next frame.
                        if (aux_bit_s && (idx_q != 4'd14)) begin
                            pend_q    <= 1'b1;
                            pend_id_q <= new_id_s;
                        end else begin
                            cur_id_q <= new_id_s;
                        end
                    end else begin
                        if (keep_s) begin
                            valid_q <= 1'b1;
                            data_q  <= scan_data_s;
                            id_q    <= cur_id_q;
                        end
                        if (idx_q[0] && pend_q) begin
                            cur_id_q <= pend_id_q;
                            pend_q   <= 1'b0;
                        end
                    end
                    if (idx_q == 4'd14) begin
                        state_q <= IDLE;
                        idx_q   <= 4'd0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                end
            endcase
            // A fresh frame always (re)starts the drain at index 0.
            if (commit_i) begin
                buf_q   <= frame_i;
                state_q <= DRAIN;
                idx_q   <= 4'd0;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;

endmodule

// File: rtl/tpiu_frame_sync.sv
// TPIU 4-bit trace port deformatter: full-sync search, frame capture and
// frame counting; decoding of committed frames is done by tpiu_frame_deformat.
module tpiu_frame_sync
    import tpiu_pkg::*;
#(
    parameter bit pNULL_DROP = 1'b1
) (
    input  logic        trace_clk,
    input  logic        reset,
    input  logic        trace_en_i,
    input  logic [3:0]  trace_data_i,
    input  logic        clear_sync_i,
    output logic        synchronized_o,
    output logic        valid_o,
    output logic [7:0]  data_o,
    output logic [6:0]  id_o,
    output logic [15:0] frame_cnt_o
);

    logic [31:0]              sr_q;
    logic [31:0]              sr_d;
    sync_state_t              sync_q;
    logic [4:0]               cnt_q;
    logic [8*FRAME_BYTES-1:0] cap_q;
    logic [8*FRAME_BYTES-1:0] cap_d;
    logic [15:0]              frame_cnt_q;
    logic                     sync_hit_s;
    logic                     capture_s;
    logic                     commit_s;

    // Sync detection on the incoming nibble, plus capture-buffer next state.
    always_comb begin
        sr_d       = {trace_data_i, sr_q[31:4]};
        sync_hit_s = trace_en_i && (sr_d == SYNC_PATTERN);
        capture_s  = (sync_q == SYNCED) && trace_en_i && !clear_sync_i && !sync_hit_s;
        commit_s   = capture_s && (cnt_q == 5'd31);
        cap_d      = cap_q;
        if (capture_s) begin
            cap_d[{cnt_q, 2'b00} +: 4] = trace_data_i;
        end else begin
            cap_d = cap_q;
        end
    end

    // Sync FSM, nibble counter, capture buffer and frame counter.
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            sr_q        <= 32'h0000_0000;
            sync_q      <= UNSYNC;
            cnt_q       <= 5'd0;
            cap_q       <= '0;
            frame_cnt_q <= 16'h0000;
        end else begin
            if (trace_en_i) begin
                sr_q <= sr_d;
            end
            case (sync_q)
                UNSYNC: begin
                    cnt_q <= 5'd0;
                    if (sync_hit_s && !clear_sync_i) begin
                        sync_q <= SYNCED;
                    end
                end
                SYNCED: begin
                    if (clear_sync_i || !trace_en_i) begin
                        sync_q <= UNSYNC;
                        cnt_q  <= 5'd0;
                    end else if (sync_hit_s) begin
                        // Realign: the partial frame is abandoned.
                        cnt_q <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                        cap_q <= cap_d;
                    end
                end
                default: begin
                    sync_q <= UNSYNC;
                    cnt_q  <= 5'd0;
                end
            endcase
            if (commit_s && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    tpiu_frame_deformat #(
        .pNULL_DROP (pNULL_DROP)
    ) u_deformat (
        .trace_clk (trace_clk),
        .reset     (reset),
        .commit_i  (commit_s),
        .frame_i   (cap_d),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .id_o      (id_o)
    );

    assign synchronized_o = (sync_q == SYNCED);
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_tpiu_frame_sync.sv
// Directed scoreboard bench for tpiu_frame_sync.
module tb_tpiu_frame_sync;

    logic        trace_clk = 1'b0;
    logic        reset;
    logic        trace_en_i;
    logic [3:0]  trace_data_i;
    logic        clear_sync_i;
    logic        synchronized_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic [6:0]  id_o;
    logic [15:0] frame_cnt_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [6:0] id;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fr [16];

    tpiu_frame_sync #(.pNULL_DROP(1'b1)) dut (
        .trace_clk      (trace_clk),
        .reset          (reset),
        .trace_en_i     (trace_en_i),
        .trace_data_i   (trace_data_i),
        .clear_sync_i   (clear_sync_i),
        .synchronized_o (synchronized_o),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .id_o           (id_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always #5 trace_clk = ~trace_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [6:0] id);
        exp_t e;
        e.d  = d;
        e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic nib(input logic [3:0] n, input logic en, input logic clr);
        trace_data_i = n;
        trace_en_i   = en;
        clear_sync_i = clr;
        @(posedge trace_clk);
        #1;
        clear_sync_i = 1'b0;
        trace_en_i   = 1'b1;
    endtask

    task automatic sync_seq(input logic clr_last);
        for (int i = 0; i < 7; i++) nib(4'hF, 1'b1, 1'b0);
        nib(4'h7, 1'b1, clr_last);
    endtask

    task automatic send(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            logic [7:0] b;
            b = fr[i / 2];
            nib(((i % 2) == 1) ? b[7:4] : b[3:0], 1'b1, 1'b0);
        end
    endtask

    // Monitor: every output strobe is matched against the expected queue.
    always @(negedge trace_clk) begin
        if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h/%0h required=none", data_o, id_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", {24'h0, data_o}, {24'h0, e.d});
                check("out_id", {25'h0, id_o}, {25'h0, e.id});
            end
        end
    end

    initial begin
        reset = 1'b1; trace_en_i = 1'b0; clear_sync_i = 1'b0; trace_data_i = 4'h0;
        repeat (3) @(posedge trace_clk);
        #1;
        check("rst_sync", {31'h0, synchronized_o}, 32'h0);
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_data", {24'h0, data_o}, 32'h0);
        check("rst_id", {25'h0, id_o}, 32'h0);
        check("rst_fcnt", {16'h0, frame_cnt_o}, 32'h0);
        reset = 1'b0;

        // Sync, then ID change to 0x10 with plain data bytes.
        for (int i = 0; i < 7; i++) nib(4'hF, 1'b1, 1'b0);
        check("sync_early", {31'h0, synchronized_o}, 32'h0);
        nib(4'h7, 1'b1, 1'b0);
        check("sync_rise", {31'h0, synchronized_o}, 32'h1);
        fr[0] = 8'h21; fr[1] = 8'hAA; fr[15] = 8'h00;
        for (int i = 2; i <= 14; i++) fr[i] = 8'(2 * (i - 1));
        push(8'hAA, 7'h10);
        for (int i = 2; i <= 14; i++) push(8'(2 * (i - 1)), 7'h10);
        send(0, 31);
        check("fcnt_1", {16'h0, frame_cnt_o}, 32'd1);

        // ID -> 0x05, then deferred change to 0x10 via aux bit 0.
        fr[0] = 8'h0B; fr[15] = 8'h00;
        for (int i = 1; i <= 14; i++) begin fr[i] = 8'(8'h40 + 2 * i); push(8'(8'h40 + 2 * i), 7'h05); end
        send(0, 31);
        fr[0] = 8'h21; fr[15] = 8'h01;
        for (int i = 1; i <= 14; i++) fr[i] = 8'(8'h60 + 2 * i);
        push(8'h62, 7'h05);
        for (int i = 2; i <= 14; i++) push(8'(8'h60 + 2 * i), 7'h10);
        send(0, 31);

        // Aux bit inserted as LSB of an even data byte.
        fr[0] = 8'h0B; fr[15] = 8'h02;
        for (int i = 1; i <= 14; i++) fr[i] = 8'(2 * i);
        fr[2] = 8'h80;
        push(8'h02, 7'h05); push(8'h81, 7'h05);
        for (int i = 3; i <= 14; i++) push(8'(2 * i), 7'h05);
        send(0, 31);
        check("fcnt_4", {16'h0, frame_cnt_o}, 32'd4);

        // Null ID drops a whole frame; next frame resumes at 0x05 and its
        // byte 14 switches to 0x12 for the following frame.
        fr[0] = 8'h01; fr[15] = 8'h00;
        for (int i = 1; i <= 14; i++) fr[i] = 8'(8'h30 + 2 * i);
        send(0, 31);
        fr[0] = 8'h0B; fr[14] = 8'h25; fr[15] = 8'h80;
        for (int i = 1; i <= 13; i++) begin fr[i] = 8'(8'h20 + 2 * i); push(8'(8'h20 + 2 * i), 7'h05); end
        send(0, 31);

        // Resync after nibble 13 drops the partial frame.
        fr[15] = 8'h00;
        for (int i = 0; i <= 14; i++) fr[i] = 8'(8'h50 + 2 * i);
        send(0, 13);
        sync_seq(1'b0);
        check("resync_sync", {31'h0, synchronized_o}, 32'h1);
        check("resync_fcnt", {16'h0, frame_cnt_o}, 32'd6);
        for (int i = 0; i <= 14; i++) push(8'(8'h50 + 2 * i), 7'h12);
        send(0, 31);
        check("fcnt_7", {16'h0, frame_cnt_o}, 32'd7);

        // Clear drops sync; clear on the last sync nibble wins.
        nib(4'h0, 1'b1, 1'b1);
        check("clr_fall", {31'h0, synchronized_o}, 32'h0);
        sync_seq(1'b1);
        check("clr_wins", {31'h0, synchronized_o}, 32'h0);
        send(0, 31);
        check("clr_nocommit", {16'h0, frame_cnt_o}, 32'd7);

        // trace_en_i low mid-frame drops sync.
        sync_seq(1'b0);
        check("en_sync", {31'h0, synchronized_o}, 32'h1);
        send(0, 9);
        nib(4'h0, 1'b0, 1'b0);
        check("en_fall", {31'h0, synchronized_o}, 32'h0);
        send(10, 31);
        check("en_nocommit", {16'h0, frame_cnt_o}, 32'd7);

        // Reset while drain index 5 is being scanned.
        sync_seq(1'b0);
        for (int i = 0; i <= 14; i++) fr[i] = 8'(8'h70 + 2 * i);
        for (int i = 0; i <= 4; i++) push(8'(8'h70 + 2 * i), 7'h12);
        send(0, 31);
        check("fcnt_8", {16'h0, frame_cnt_o}, 32'd8);
        repeat (5) nib(4'h0, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge trace_clk);
        #1;
        check("mid_rst_valid", {31'h0, valid_o}, 32'h0);
        check("mid_rst_id", {25'h0, id_o}, 32'h0);
        check("mid_rst_data", {24'h0, data_o}, 32'h0);
        check("mid_rst_fcnt", {16'h0, frame_cnt_o}, 32'h0);
        check("mid_rst_sync", {31'h0, synchronized_o}, 32'h0);
        check("mid_rst_queue", exp_q.size(), 32'd0);
        reset = 1'b0;

        // After resync the ID is back at 0x00 (dropped), then 0x05.
        sync_seq(1'b0);
        fr[0] = 8'h10; fr[15] = 8'h00;
        for (int i = 1; i <= 14; i++) fr[i] = 8'(8'h80 + 2 * i);
        send(0, 31);
        fr[0] = 8'h0B;
        for (int i = 1; i <= 14; i++) begin fr[i] = 8'(8'h90 + 2 * i); push(8'(8'h90 + 2 * i), 7'h05); end
        send(0, 31);
        trace_en_i = 1'b0;
        repeat (40) @(posedge trace_clk);
        #1;
        check("end_queue", exp_q.size(), 32'd0);
        check("end_fcnt", {16'h0, frame_cnt_o}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
